clk_en_nco: RTL and testbench

- Multi-channel phase-accumulator (NCO) clock-enable generator, driven by the rPLL output clock.
- Derives fractional-rate single-cycle enables (for example UART, audio, timer and video ticks) without extra PLLs.
- A lock supervisor gates all enables until the PLL lock has been stable for a programmable filter time.
- Per-channel rate changes are glitch-free: they take effect only at an accumulator wrap.

---
 rtl/clk_en_nco_pkg.sv | 19 +
 rtl/clk_en_nco_channel.sv | 93 +++++++++
 rtl/clk_en_nco.sv | 125 ++++++++++++
 tb/tb_clk_en_nco.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_nco_pkg.sv
// Shared types and constants for the clk_en_nco clock-enable generator.
// The optional square-wave outputs are enabled with the macro CLK_EN_NCO_SQUARE_EN.
package clk_en_nco_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RUN       = 2'd2
  } sup_state_e;

  localparam int ACC_W_MAX = 32;
  localparam int CH_MAX    = 8;

  // Width of the lock-filter counter; it must hold values up to LOCK_FILT-1.
  function automatic int filt_cnt_w(input int lock_filt);
    return (lock_filt < 2) ? 1 : $clog2(lock_filt);
  endfunction

endpackage

// File: rtl/clk_en_nco_channel.sv
// One NCO channel: shadow/active increment, phase accumulator and the ce pulse flop.
// With CLK_EN_NCO_SQUARE_EN defined it also registers the accumulator MSB as a square wave.
module nco_channel
  import clk_en_nco_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clr,
  input  logic             ch_en,
  input  logic             inc_ld,
  input  logic [ACC_W-1:0] inc,
  output logic             ce
`ifdef CLK_EN_NCO_SQUARE_EN
  ,
  output logic             sq
`endif
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic [ACC_W-1:0] active_q, active_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  logic             step;
`ifdef CLK_EN_NCO_SQUARE_EN
  logic             sq_q, sq_d;
`endif

  // Next-state: accumulate while running; increment swaps only at a wrap or when idle.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, active_q};
    step     = run & ch_en;
    acc_d    = acc_q;
    active_d = active_q;
    ce_d     = 1'b0;
    if (clr) begin
      acc_d    = {ACC_W{1'b0}};
      active_d = shadow_q;
    end else if (step) begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = sum[ACC_W];
      if (sum[ACC_W]) begin
        active_d = shadow_q;
      end else begin
        active_d = active_q;
      end
    end else begin
      active_d = shadow_q;
    end
    if (inc_ld) begin
      shadow_d = inc;
    end else begin
      shadow_d = shadow_q;
    end
`ifdef CLK_EN_NCO_SQUARE_EN
    if (step) begin
      sq_d = acc_d[ACC_W-1];
    end else begin
      sq_d = 1'b0;
    end
`endif
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= {ACC_W{1'b0}};
      shadow_q <= {ACC_W{1'b0}};
      active_q <= {ACC_W{1'b0}};
      ce_q     <= 1'b0;
`ifdef CLK_EN_NCO_SQUARE_EN
      sq_q     <= 1'b0;
`endif
    end else begin
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ce_q     <= ce_d;
`ifdef CLK_EN_NCO_SQUARE_EN
      sq_q     <= sq_d;
`endif
    end
  end

  assign ce = ce_q;
`ifdef CLK_EN_NCO_SQUARE_EN
  assign sq = sq_q;
`endif

endmodule

// File: rtl/clk_en_nco.sv
// Multi-channel NCO clock-enable generator with a PLL lock supervisor.
// Define CLK_EN_NCO_SQUARE_EN to add the per-channel square-wave output sq.
module clk_en_nco
  import clk_en_nco_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int ACC_W     = 24,
  parameter int LOCK_FILT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pll_lock,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  input  logic [CHANNELS-1:0]       inc_ld,
  input  logic [CHANNELS-1:0]       ch_en,
  output logic [CHANNELS-1:0]       ce,
  output logic                      ready,
  output logic                      lock_lost
`ifdef CLK_EN_NCO_SQUARE_EN
  ,
  output logic [CHANNELS-1:0]       sq
`endif
);

  localparam int CNT_W = filt_cnt_w(LOCK_FILT);

  logic             sync1_q, sync2_q;
  logic             lock_s;
  sup_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             lost_q, lost_d;
  logic             run_s, clr_s;

  assign lock_s = sync2_q;

  // Supervisor next state; the WAIT_LOCK cycle that sees lock counts as the first good cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = FILTER;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = WAIT_LOCK;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      FILTER: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = FILTER;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = {CNT_W{1'b0}};
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    ready_d = (state_d == RUN);
    lost_d  = lost_q | ((state_q == RUN) & ~lock_s);
  end

  // Synchroniser, supervisor state and its registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= WAIT_LOCK;
      cnt_q   <= {CNT_W{1'b0}};
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  // Losing lock in RUN clears every accumulator on the same edge that leaves RUN.
  assign run_s = (state_q == RUN) & lock_s;
  assign clr_s = (state_q == RUN) & ~lock_s;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    nco_channel #(
      .ACC_W(ACC_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .run   (run_s),
      .clr   (clr_s),
      .ch_en (ch_en[g]),
      .inc_ld(inc_ld[g]),
      .inc   (inc[g*ACC_W +: ACC_W]),
      .ce    (ce[g])
`ifdef CLK_EN_NCO_SQUARE_EN
      ,
      .sq    (sq[g])
`endif
    );
  end

  assign ready     = ready_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_clk_en_nco.sv
// Self-checking bench for clk_en_nco: table of full-cycle pulse counts, hand-written
// lock/ratio/update sequences and randomized traffic against a behavioural model.
module tb_clk_en_nco;

  localparam int CH  = 4;
  localparam int AW  = 8;
  localparam int LF  = 16;
  localparam int MOD = 1 << AW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pll_lock = 1'b0;
  logic [CH*AW-1:0]  inc = '0;
  logic [CH-1:0]     inc_ld = '0;
  logic [CH-1:0]     ch_en = '0;
  logic [CH-1:0]     ce;
  logic              ready;
  logic              lock_lost;
`ifdef CLK_EN_NCO_SQUARE_EN
  logic [CH-1:0]     sq;
`endif

  clk_en_nco #(.CHANNELS(CH), .ACC_W(AW), .LOCK_FILT(LF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pll_lock (pll_lock),
    .inc      (inc),
    .inc_ld   (inc_ld),
    .ch_en    (ch_en),
    .ce       (ce),
    .ready    (ready),
    .lock_lost(lock_lost)
`ifdef CLK_EN_NCO_SQUARE_EN
    ,
    .sq       (sq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: lock streak counting, modular phase arithmetic per channel.
  int            m_acc [CH];
  int            m_act [CH];
  int            m_shd [CH];
  logic [CH-1:0] m_ce;
  logic [CH-1:0] m_sq;
  bit            m_h1, m_h2, m_run, m_lost;
  int            m_streak;

  task automatic model_step();
    bit ls, was, drop, go;
    int s;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0; m_act[c] = 0; m_shd[c] = 0;
      end
      m_ce = '0; m_sq = '0;
      m_h1 = 0; m_h2 = 0; m_run = 0; m_lost = 0; m_streak = 0;
    end else begin
      ls   = m_h2;
      m_h2 = m_h1;
      m_h1 = pll_lock;
      was  = m_run;
      drop = was && !ls;
      if (!ls) begin
        m_streak = 0;
        m_run    = 0;
      end else begin
        m_streak++;
        if (m_streak >= LF) m_run = 1;
      end
      if (drop) m_lost = 1;
      for (int c = 0; c < CH; c++) begin
        go = was && ls && ch_en[c];
        if (go) begin
          s        = m_acc[c] + m_act[c];
          m_ce[c]  = (s >= MOD);
          m_acc[c] = s % MOD;
          if (s >= MOD) m_act[c] = m_shd[c];
        end else begin
          m_ce[c]  = 1'b0;
          m_act[c] = m_shd[c];
          if (drop) m_acc[c] = 0;
        end
        m_sq[c] = go && (m_acc[c] >= MOD / 2);
        if (inc_ld[c]) m_shd[c] = int'(inc[c*AW +: AW]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_ready", ready, m_run);
    chk("model_lock_lost", lock_lost, m_lost);
    chk("model_ce", ce, m_ce);
`ifdef CLK_EN_NCO_SQUARE_EN
    chk("model_sq", sq, m_sq);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int n, output logic [CH-1:0] pre_ce);
    n = 0;
    pre_ce = '0;
    while (!ready && n < 200) begin
      tick();
      n++;
      if (!ready) pre_ce |= ce;
    end
    chk("ready_timeout", ready, 1'b1);
  endtask

  task automatic load_all(input logic [CH*AW-1:0] v);
    inc    = v;
    inc_ld = '1;
    tick();
    inc_ld = '0;
  endtask

  typedef struct {
    logic [CH*AW-1:0] inc_v;
    int               exp_cnt [CH];
  } vec_t;

  vec_t tbl [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            cnt [CH];
    logic [CH-1:0] pre;
    logic [7:0]    pat96;
    int            glitch;
    bit            e2;

    tbl[0].inc_v = {8'd255, 8'd128, 8'd1, 8'd0};
    tbl[0].exp_cnt = '{0, 1, 128, 255};
    tbl[1].inc_v = {8'd200, 8'd3, 8'd96, 8'd64};
    tbl[1].exp_cnt = '{64, 96, 3, 200};
    tbl[2].inc_v = {8'd129, 8'd127, 8'd250, 8'd17};
    tbl[2].exp_cnt = '{17, 250, 127, 129};
    pat96 = 8'b1010_0100;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ce", ce, 4'b0000);
    chk("rst_ready", ready, 1'b0);
    chk("rst_lock_lost", lock_lost, 1'b0);

    // Table: 2^ACC_W additions from acc=0 give exactly 'inc' pulses per channel
    for (int t = 0; t < 3; t++) begin
      pll_lock = 1'b0;
      ch_en    = '0;
      do_reset();
      load_all(tbl[t].inc_v);
      pll_lock = 1'b1;
      wait_ready(n, pre);
      ch_en = '1;
      for (int c = 0; c < CH; c++) cnt[c] = 0;
      repeat (MOD) begin
        tick();
        for (int c = 0; c < CH; c++) if (ce[c]) cnt[c]++;
      end
      ch_en = '0;
      for (int c = 0; c < CH; c++) chk($sformatf("tbl%0d_cnt_ch%0d", t, c), cnt[c], tbl[t].exp_cnt[c]);
    end

    // Lock filter latency: 2 synchroniser cycles + LOCK_FILT
    pll_lock = 1'b0;
    ch_en    = '0;
    do_reset();
    repeat (5) tick();
    load_all({8'd255, 8'd32, 8'd96, 8'd64});
    ch_en    = '1;
    pll_lock = 1'b1;
    wait_ready(n, pre);
    chk("lock_latency", n, 18);
    chk("ce_before_ready", pre, 4'b0000);

    // Exact ratios and glitch-free update of channel 2 (32 -> 128 mid-period)
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("ratio64_k%0d", k), ce[0], (k % 4) == 0);
      chk($sformatf("ratio96_k%0d", k), ce[1], pat96[(k - 1) % 8]);
      chk($sformatf("ratio255_k%0d", k), ce[3], k != 1);
      if (k <= 16) e2 = (k % 8) == 0;
      else         e2 = (k == 24) || (k > 24 && (k % 2) == 0);
      chk($sformatf("update_k%0d", k), ce[2], e2);
      if (k == 19) begin
        inc[2*AW +: AW] = 8'd128;
        inc_ld = 4'b0100;
      end else begin
        inc_ld = 4'b0000;
      end
    end

    // Channel gating: ch 1 frozen for 5 cycles, others keep running (model checks resume point)
    ch_en[1] = 1'b0;
    repeat (5) begin
      tick();
      chk("gated_ce1", ce[1], 1'b0);
    end
    ch_en[1] = 1'b1;
    repeat (16) tick();

    // Lock lost in RUN for 3 cycles
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    repeat (3) tick();
    chk("drop_ready", ready, 1'b0);
    chk("drop_lock_lost", lock_lost, 1'b1);

    // One-cycle glitch during FILTER restarts the full filter
    repeat (4) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_ready(n, pre);
    chk("glitch_latency", n, 18);
    chk("lost_sticky", lock_lost, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("cleared_acc_k%0d", k), ce[0], (k % 4) == 0);
    end

`ifdef CLK_EN_NCO_SQUARE_EN
    // Square wave: inc=16 gives period 16, high for 8
    ch_en = '0;
    do_reset();
    load_all({8'd0, 8'd0, 8'd0, 8'd16});
    ch_en = 4'b0001;
    wait_ready(n, pre);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("sq_k%0d", k), sq[0], (k % 16) >= 8);
    end
    reset = 1'b1;
    tick();
    chk("sq_after_reset", sq, 4'b0000);
    reset = 1'b0;
`endif

    // Randomized traffic against the model
    ch_en = '1;
    do_reset();
    glitch = 0;
    for (int i = 0; i < 1500; i++) begin
      inc    = $urandom;
      inc_ld = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom);
      if (glitch > 0) begin
        pll_lock = 1'b0;
        glitch--;
      end else if ($urandom_range(0, 149) == 0) begin
        pll_lock = 1'b0;
        glitch   = $urandom_range(0, 3);
      end else begin
        pll_lock = 1'b1;
      end
      reset = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset = 1'b0;
    inc_ld = '0;

    // Reset while running clears everything including the sticky flag
    pll_lock = 1'b1;
    wait_ready(n, pre);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk("midrun_rst_ce", ce, 4'b0000);
    chk("midrun_rst_ready", ready, 1'b0);
    chk("midrun_rst_lock_lost", lock_lost, 1'b0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
